// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//
// Shares one single-port block RAM between two requesters:
//   SD port - DAT-line engine (fills RAM on multi-block reads, drains it on
//             multi-block writes).
//   CR port - OTP/cipher engine (in-place read-modify-write).
//
// Ownership is burst-oriented: the owner keeps the RAM while it requests or
// holds its lock. Contention from IDLE is resolved round-robin against the
// last port to give up the RAM. A waiting port preempts the owner after
// MAX_WAIT cycles of continuous request.
//
// Ports
//   iclk, irst              clock, asynchronous active-high reset
//   ireq_X / ilock_X        access request / hold grant across request gaps
//   iwe_X, iaddr_X,
//   iwdata_X                access type, word address, write data
//   ogrant_X                port X owns the RAM (decoded from state)
//   ovalid_X                read data on ordata belongs to port X
//   ordata                  shared read data (straight from the RAM)
//   oram_en/we/addr/wdata   RAM primitive control, muxed from the owner
//   iram_rdata              RAM read data, 1-cycle latency
//   opreempt                1-cycle pulse on the first cycle of a grant that
//                           was forced by the starvation limit
// ---------------------------------------------------------------------------
module ram_arbiter #(
  parameter int RAM_BLOCKS = 8,
  parameter int DATA_W     = 4,
  parameter int ADDR_W     = $clog2(RAM_BLOCKS * 1024),
  parameter int MAX_WAIT   = 64
) (
  input  logic              iclk,
  input  logic              irst,
  // SD port
  input  logic              ireq_sd,
  input  logic              ilock_sd,
  input  logic              iwe_sd,
  input  logic [ADDR_W-1:0] iaddr_sd,
  input  logic [DATA_W-1:0] iwdata_sd,
  output logic              ogrant_sd,
  output logic              ovalid_sd,
  // CR port
  input  logic              ireq_cr,
  input  logic              ilock_cr,
  input  logic              iwe_cr,
  input  logic [ADDR_W-1:0] iaddr_cr,
  input  logic [DATA_W-1:0] iwdata_cr,
  output logic              ogrant_cr,
  output logic              ovalid_cr,
  // Shared read data
  output logic [DATA_W-1:0] ordata,
  // RAM primitive
  output logic              oram_en,
  output logic              oram_we,
  output logic [ADDR_W-1:0] oram_addr,
  output logic [DATA_W-1:0] oram_wdata,
  input  logic [DATA_W-1:0] iram_rdata,
  // Status
  output logic              opreempt
);

  localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT - 1);

  // last_q records which port most recently gave up the RAM.
  localparam logic LAST_SD = 1'b0;
  localparam logic LAST_CR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SD   = 2'd1,
    ST_CR   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             preempt_q, preempt_d;
  logic             vld_sd_q, vld_sd_d;
  logic             vld_cr_q, vld_cr_d;

  logic             starve;
  logic             hold_sd, hold_cr;

  // Owner wants to keep the RAM this cycle.
  assign hold_sd = ireq_sd | ilock_sd;
  assign hold_cr = ireq_cr | ilock_cr;

  // The counter only advances while the non-owner is requesting, so
  // reaching the limit already implies a waiting port; the request term is
  // kept so a request that drops on the final cycle does not force a swap.
  always_comb begin
    starve = 1'b0;
    if (wait_cnt_q == WAIT_LIM) begin
      starve = (state_q == ST_SD) ? ireq_cr :
               (state_q == ST_CR) ? ireq_sd : 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q    <= ST_IDLE;
      last_q     <= LAST_CR;
      wait_cnt_q <= '0;
      preempt_q  <= 1'b0;
      vld_sd_q   <= 1'b0;
      vld_cr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      wait_cnt_q <= wait_cnt_d;
      preempt_q  <= preempt_d;
      vld_sd_q   <= vld_sd_d;
      vld_cr_q   <= vld_cr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // A port's lock is only consulted while it owns the RAM, so a preempted
  // port's lock has no effect until it is granted again.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    preempt_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ireq_sd && ireq_cr) begin
          state_d = (last_q == LAST_CR) ? ST_SD : ST_CR;
        end else if (ireq_sd) begin
          state_d = ST_SD;
        end else if (ireq_cr) begin
          state_d = ST_CR;
        end
      end

      ST_SD: begin
        if (!hold_sd || starve) begin
          state_d   = ireq_cr ? ST_CR : ST_IDLE;
          last_d    = LAST_SD;
          // Only a swap the owner did not ask for counts as a preemption.
          preempt_d = starve & hold_sd;
        end
      end

      ST_CR: begin
        if (!hold_cr || starve) begin
          state_d   = ireq_sd ? ST_SD : ST_IDLE;
          last_d    = LAST_CR;
          preempt_d = starve & hold_cr;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (((state_q == ST_SD) && ireq_cr) ||
                 ((state_q == ST_CR) && ireq_sd)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end else begin
      wait_cnt_d = '0;
    end
  end

  // -------------------------------------------------------------------------
  // Output logic: grant decode, RAM mux, read-valid tagging
  // The valid is tagged with the port that issued the read, so a read
  // accepted on the last cycle of a grant still returns to its issuer.
  // -------------------------------------------------------------------------
  always_comb begin
    ogrant_sd  = (state_q == ST_SD);
    ogrant_cr  = (state_q == ST_CR);
    oram_en    = 1'b0;
    oram_we    = 1'b0;
    oram_addr  = '0;
    oram_wdata = '0;

    case (state_q)
      ST_SD: begin
        oram_en    = ireq_sd;
        oram_we    = ireq_sd & iwe_sd;
        oram_addr  = iaddr_sd;
        oram_wdata = iwdata_sd;
      end
      ST_CR: begin
        oram_en    = ireq_cr;
        oram_we    = ireq_cr & iwe_cr;
        oram_addr  = iaddr_cr;
        oram_wdata = iwdata_cr;
      end
      default: begin
        oram_en = 1'b0;
      end
    endcase

    vld_sd_d = ogrant_sd & ireq_sd & ~iwe_sd;
    vld_cr_d = ogrant_cr & ireq_cr & ~iwe_cr;
  end

  assign ovalid_sd = vld_sd_q;
  assign ovalid_cr = vld_cr_q;
  assign opreempt  = preempt_q;
  assign ordata    = iram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
//
// Directed bench for ram_arbiter. A behavioural RAM returns addr[3:0]^4'hA
// one cycle after a read so read data can be predicted by hand.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// there as well, well clear of the active edge.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;

  localparam int DATA_W   = 4;
  localparam int ADDR_W   = 13;
  localparam int MAX_WAIT = 64;

  logic              iclk = 1'b0;
  logic              irst = 1'b0;
  logic              ireq_sd, ilock_sd, iwe_sd;
  logic [ADDR_W-1:0] iaddr_sd;
  logic [DATA_W-1:0] iwdata_sd;
  logic              ogrant_sd, ovalid_sd;
  logic              ireq_cr, ilock_cr, iwe_cr;
  logic [ADDR_W-1:0] iaddr_cr;
  logic [DATA_W-1:0] iwdata_cr;
  logic              ogrant_cr, ovalid_cr;
  logic [DATA_W-1:0] ordata;
  logic              oram_en, oram_we;
  logic [ADDR_W-1:0] oram_addr;
  logic [DATA_W-1:0] oram_wdata;
  logic [DATA_W-1:0] iram_rdata = '0;
  logic              opreempt;

  int checks = 0;
  int errors = 0;

  // {ogrant_sd, ogrant_cr, ovalid_sd, ovalid_cr, opreempt, oram_en}
  logic [5:0] flags;
  assign flags = {ogrant_sd, ogrant_cr, ovalid_sd, ovalid_cr, opreempt, oram_en};

  ram_arbiter #(
    .RAM_BLOCKS(8),
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MAX_WAIT  (MAX_WAIT)
  ) dut (
    .iclk      (iclk),
    .irst      (irst),
    .ireq_sd   (ireq_sd),
    .ilock_sd  (ilock_sd),
    .iwe_sd    (iwe_sd),
    .iaddr_sd  (iaddr_sd),
    .iwdata_sd (iwdata_sd),
    .ogrant_sd (ogrant_sd),
    .ovalid_sd (ovalid_sd),
    .ireq_cr   (ireq_cr),
    .ilock_cr  (ilock_cr),
    .iwe_cr    (iwe_cr),
    .iaddr_cr  (iaddr_cr),
    .iwdata_cr (iwdata_cr),
    .ogrant_cr (ogrant_cr),
    .ovalid_cr (ovalid_cr),
    .ordata    (ordata),
    .oram_en   (oram_en),
    .oram_we   (oram_we),
    .oram_addr (oram_addr),
    .oram_wdata(oram_wdata),
    .iram_rdata(iram_rdata),
    .opreempt  (opreempt)
  );

  always #5 iclk = ~iclk;

  // Behavioural RAM: 1-cycle read latency, content pattern addr[3:0]^A.
  always @(posedge iclk) begin
    if (oram_en && !oram_we) iram_rdata <= oram_addr[3:0] ^ 4'hA;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic clear_inputs();
    ireq_sd = 0; ilock_sd = 0; iwe_sd = 0; iaddr_sd = '0; iwdata_sd = '0;
    ireq_cr = 0; ilock_cr = 0; iwe_cr = 0; iaddr_cr = '0; iwdata_cr = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    irst = 1'b1;
    tick();
    irst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    irst = 1'b1;
    tick();
    tick();
    checks++;
    if (flags !== 6'b000000) begin
      errors++; $display("FAIL reset_flags: got %b required %b", flags, 6'b000000);
    end
    checks++;
    if ({oram_we, oram_addr, oram_wdata} !== '0) begin
      errors++; $display("FAIL reset_mux: got we=%b addr=%h wdata=%h required 0/0/0",
                         oram_we, oram_addr, oram_wdata);
    end
    irst = 1'b0;
    tick();
    checks++;
    if (flags !== 6'b000000) begin
      errors++; $display("FAIL idle_after_reset: got %b required %b", flags, 6'b000000);
    end
  endtask

  task automatic test_single_read();
    ireq_sd = 1; iwe_sd = 0; iaddr_sd = 13'h005;
    #1;
    checks++;
    if (oram_en !== 1'b0) begin
      errors++; $display("FAIL idle_no_en: got %b required 0", oram_en);
    end
    tick();
    checks++;
    if ({flags, oram_we, oram_addr} !== {6'b100001, 1'b0, 13'h005}) begin
      errors++; $display("FAIL sd_grant: got flags=%b we=%b addr=%h required 100001/0/005",
                         flags, oram_we, oram_addr);
    end
    tick();
    ireq_sd = 0;
    #1;
    checks++;
    if ({flags, ordata} !== {6'b101000, 4'hF}) begin
      errors++; $display("FAIL sd_read_valid: got flags=%b data=%h required 101000/f",
                         flags, ordata);
    end
    tick();
    checks++;
    if (flags !== 6'b000000) begin
      errors++; $display("FAIL sd_release: got %b required 000000", flags);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    ireq_sd = 1; iaddr_sd = 13'h001;
    ireq_cr = 1; iaddr_cr = 13'h002;
    tick();
    checks++;
    if ({ogrant_sd, ogrant_cr, oram_addr} !== {2'b10, 13'h001}) begin
      errors++; $display("FAIL first_contention: got grants=%b addr=%h required 10/001",
                         {ogrant_sd, ogrant_cr}, oram_addr);
    end
    tick();
    ireq_sd = 0;
    #1;
    checks++;
    if ({flags, ordata} !== {6'b101000, 4'hB}) begin
      errors++; $display("FAIL sd_before_handover: got flags=%b data=%h required 101000/b",
                         flags, ordata);
    end
    tick();
    checks++;
    if ({flags, oram_addr} !== {6'b010001, 13'h002}) begin
      errors++; $display("FAIL handover_no_gap: got flags=%b addr=%h required 010001/002",
                         flags, oram_addr);
    end
    ireq_cr = 0;
    tick();
    checks++;
    if (flags !== 6'b000000) begin
      errors++; $display("FAIL cr_release: got %b required 000000", flags);
    end
    // CR exited last: SD wins.
    ireq_sd = 1; ireq_cr = 1;
    tick();
    checks++;
    if ({ogrant_sd, ogrant_cr} !== 2'b10) begin
      errors++; $display("FAIL rr_sd: got %b required 10", {ogrant_sd, ogrant_cr});
    end
    ireq_sd = 0; ireq_cr = 0;
    tick();
    // SD exited last: CR wins.
    ireq_sd = 1; ireq_cr = 1;
    tick();
    checks++;
    if ({ogrant_sd, ogrant_cr} !== 2'b01) begin
      errors++; $display("FAIL rr_cr: got %b required 01", {ogrant_sd, ogrant_cr});
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_lock_burst();
    ireq_cr = 1; ilock_cr = 1; iwe_cr = 1; iaddr_cr = 13'h010; iwdata_cr = 4'h3;
    tick();
    checks++;
    if ({ogrant_sd, ogrant_cr, oram_en, oram_we, oram_addr, oram_wdata} !==
        {4'b0111, 13'h010, 4'h3}) begin
      errors++; $display("FAIL lock_write1: got g/en/we=%b addr=%h wdata=%h required 0111/010/3",
                         {ogrant_sd, ogrant_cr, oram_en, oram_we}, oram_addr, oram_wdata);
    end
    tick();
    ireq_cr = 0;
    #1;
    checks++;
    if ({ogrant_sd, ogrant_cr, oram_en, oram_we} !== 4'b0100) begin
      errors++; $display("FAIL lock_gap: got %b required 0100",
                         {ogrant_sd, ogrant_cr, oram_en, oram_we});
    end
    tick();
    checks++;
    if ({ogrant_sd, ogrant_cr, oram_en, oram_we} !== 4'b0100) begin
      errors++; $display("FAIL lock_held: got %b required 0100",
                         {ogrant_sd, ogrant_cr, oram_en, oram_we});
    end
    ireq_cr = 1; iaddr_cr = 13'h011; iwdata_cr = 4'h7;
    #1;
    checks++;
    if ({ogrant_sd, ogrant_cr, oram_en, oram_we, ovalid_cr, oram_addr, oram_wdata} !==
        {5'b01110, 13'h011, 4'h7}) begin
      errors++; $display("FAIL lock_write2: got g/en/we/v=%b addr=%h wdata=%h required 01110/011/7",
                         {ogrant_sd, ogrant_cr, oram_en, oram_we, ovalid_cr}, oram_addr, oram_wdata);
    end
    tick();
    ireq_cr = 0; ilock_cr = 0;
    tick();
    checks++;
    if (flags !== 6'b000000) begin
      errors++; $display("FAIL lock_release: got %b required 000000", flags);
    end
    clear_inputs();
  endtask

  task automatic test_starvation();
    ireq_cr = 1; ilock_cr = 1; iwe_cr = 1; iaddr_cr = 13'h020;
    tick();
    ireq_sd = 1; iwe_sd = 0; iaddr_sd = 13'h030;
    ireq_cr = 0;
    // 63 edges keep CR; the 64th edge hands over.
    for (int i = 0; i < MAX_WAIT - 1; i++) begin
      tick();
      checks++;
      if ({ogrant_sd, ogrant_cr, opreempt} !== 3'b010) begin
        errors++; $display("FAIL starve_hold cycle %0d: got %b required 010",
                           i, {ogrant_sd, ogrant_cr, opreempt});
      end
    end
    // CR read in the handover cycle.
    ireq_cr = 1; iwe_cr = 0; iaddr_cr = 13'h021;
    tick();
    checks++;
    if ({flags, ordata, oram_addr} !== {6'b100111, 4'hB, 13'h030}) begin
      errors++; $display("FAIL preempt_handover: got flags=%b data=%h addr=%h required 100111/b/030",
                         flags, ordata, oram_addr);
    end
    tick();
    checks++;
    if ({flags, ordata} !== {6'b101001, 4'hA}) begin
      errors++; $display("FAIL preempt_pulse_once: got flags=%b data=%h required 101001/a",
                         flags, ordata);
    end
    ireq_sd = 0;
    tick();
    checks++;
    if ({ogrant_sd, ogrant_cr, opreempt} !== 3'b010) begin
      errors++; $display("FAIL back_to_cr: got %b required 010",
                         {ogrant_sd, ogrant_cr, opreempt});
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_midburst();
    ireq_sd = 1; iwe_sd = 0; iaddr_sd = 13'h040;
    tick();
    tick();
    checks++;
    if (flags !== 6'b101001) begin
      errors++; $display("FAIL midburst_pre: got %b required 101001", flags);
    end
    irst = 1'b1;
    #1;
    checks++;
    if (flags !== 6'b000000) begin
      errors++; $display("FAIL reset_immediate: got %b required 000000", flags);
    end
    tick();
    checks++;
    if (flags !== 6'b000000) begin
      errors++; $display("FAIL reset_held: got %b required 000000", flags);
    end
    irst = 1'b0;
    ireq_cr = 1;
    tick();
    checks++;
    if ({ogrant_sd, ogrant_cr} !== 2'b10) begin
      errors++; $display("FAIL post_reset_rr: got %b required 10", {ogrant_sd, ogrant_cr});
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_lock_burst();
    test_starvation();
    test_reset_midburst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
